// File: rtl/cvt_req_scheduler.sv
// Round-robin scheduler sharing one int-to-float conversion unit between NREQ
// requesters through a two-stage valid/ready pipeline; results carry the requester tag.

module cvt_conversion_unit (
  input  logic        is_unsigned_i,
  input  logic [1:0]  rm_i,
  input  logic [31:0] i_i,
  output logic [31:0] f_o
);

  typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RDN, RM_RUP} rm_e;

  logic        sign;
  logic [31:0] mag;
  logic [4:0]  lz;
  logic [31:0] norm;
  logic [7:0]  exp_raw;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic [30:0] rounded;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    sign = !is_unsigned_i && i_i[31];
    mag  = sign ? (~i_i + 32'd1) : i_i;
    lz   = 5'd0;
    // Scan upward so the highest set bit is the last (winning) assignment.
    for (int b = 0; b < 32; b++) begin
      if (mag[b]) lz = 5'(31 - b);
    end
    norm    = mag << lz;
    exp_raw = 8'd158 - {3'b000, lz};
    mant    = norm[30:8];
    guard   = norm[7];
    sticky  = |norm[6:0];
    inc     = 1'b0;
    case (rm_e'(rm_i))
      RM_RNE: inc = guard && (sticky || mant[0]);
      RM_RTZ: inc = 1'b0;
      RM_RDN: inc = sign && (guard || sticky);
      RM_RUP: inc = !sign && (guard || sticky);
      default: inc = 1'b0;
    endcase
    // A mantissa carry-out rolls naturally into the exponent field.
    rounded = {exp_raw, mant} + {30'd0, inc};
    f_o     = (mag == 32'd0) ? 32'd0 : {sign, rounded};
  end

endmodule

module cvt_req_scheduler #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_is_unsigned,
  input  logic [2*NREQ-1:0]    req_rm,
  input  logic [32*NREQ-1:0]   req_i,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_f,
  output logic [IDW-1:0]       resp_id,
  output logic                 idle
);

  logic            s1_valid_q, s1_valid_d;
  logic            s1_uns_q, s1_uns_d;
  logic [1:0]      s1_rm_q, s1_rm_d;
  logic [31:0]     s1_i_q, s1_i_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [31:0]     s2_f_q, s2_f_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            s1_adv, s2_adv;
  logic            grant_valid;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    arb_sum;
  logic [IDW-1:0]  arb_idx;
  logic            accept;
  logic [31:0]     cvt_f;

  assign s2_adv = !s2_valid_q || resp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Walk from the farthest candidate back to rr_ptr so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    arb_sum     = '0;
    arb_idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      arb_sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
      if (arb_sum >= (IDW + 1)'(NREQ)) arb_sum = arb_sum - (IDW + 1)'(NREQ);
      arb_idx = arb_sum[IDW-1:0];
      if (req_valid[arb_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = arb_idx;
      end
    end
  end

  assign accept = grant_valid && s1_adv && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  cvt_conversion_unit u_cvt (
    .is_unsigned_i (s1_uns_q),
    .rm_i          (s1_rm_q),
    .i_i           (s1_i_q),
    .f_o           (cvt_f)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_uns_d   = s1_uns_q;
    s1_rm_d    = s1_rm_q;
    s1_i_d     = s1_i_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_f_d     = s2_f_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;

    if (s1_adv) s1_valid_d = accept;
    if (accept) begin
      s1_uns_d = req_is_unsigned[grant_idx];
      s1_rm_d  = req_rm[{grant_idx, 1'b0} +: 2];
      s1_i_d   = req_i[{grant_idx, 5'b00000} +: 32];
      s1_id_d  = grant_idx;
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_f_d     = cvt_f;
      s2_id_d    = s1_id_q;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: payload registers are reset too, because resp_f/resp_id must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_uns_q   <= 1'b0;
      s1_rm_q    <= 2'b00;
      s1_i_q     <= 32'd0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_f_q     <= 32'd0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_uns_q   <= s1_uns_d;
      s1_rm_q    <= s1_rm_d;
      s1_i_q     <= s1_i_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_f_q     <= s2_f_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign resp_valid = s2_valid_q;
  assign resp_f     = s2_f_q;
  assign resp_id    = s2_id_q;
  assign idle       = !s1_valid_q && !s2_valid_q;

endmodule

// File: tb/tb_cvt_req_scheduler.sv
// Bench for cvt_req_scheduler: queue-based reference model compared every cycle,
// plus directed vectors with literal expected results.

module tb_cvt_req_scheduler;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  typedef struct { bit uns; bit [1:0] rm; bit [31:0] x; } op_t;
  typedef struct { int id; bit [31:0] f; int age; } ent_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_is_unsigned;
  logic [2*NREQ-1:0]   req_rm;
  logic [32*NREQ-1:0]  req_i;
  logic                resp_valid;
  logic                resp_ready;
  logic [31:0]         resp_f;
  logic [IDW-1:0]      resp_id;
  logic                idle;

  cvt_req_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_unsigned (req_is_unsigned),
    .req_rm          (req_rm),
    .req_i           (req_i),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_f          (resp_f),
    .resp_id         (resp_id),
    .idle            (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  op_t             drv_q[NREQ][$];
  ent_t            mq[$];
  int              m_ptr = 0;
  logic [NREQ-1:0] acc_seen = '0;
  bit              pend_pop = 0;
  bit              pend_acc = 0;
  int              pend_id  = 0;
  bit [31:0]       pend_f   = 0;

  int        acc_cyc[$];
  int        acc_id[$];
  int        rsp_cyc[$];
  int        rsp_id[$];
  bit [31:0] rsp_f[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference conversion by integer division/remainder, not by bit scanning.
  function automatic bit [31:0] model_cvt(input bit uns, input bit [1:0] rm, input bit [31:0] x);
    longint m, q, r, half;
    int     e, sh;
    bit     neg, up;
    if (uns) m = longint'({32'b0, x});
    else     m = longint'($signed(x));
    neg = (m < 0);
    if (neg) m = -m;
    if (m == 0) return 32'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = longint'(1) << (sh - 1);
      up   = 0;
      case (rm)
        2'd0: up = (r > half) || (r == half && q[0]);
        2'd1: up = 0;
        2'd2: up = neg && (r != 0);
        default: up = !neg && (r != 0);
      endcase
      if (up) q++;
      if (q == (longint'(1) << 24)) begin
        q = longint'(1) << 23;
        e++;
      end
    end
    return {neg, 8'(e + 127), 23'(q)};
  endfunction

  // Driver: present each requester's head op until it is accepted.
  always @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREQ; r++)
        if (acc_seen[r] && drv_q[r].size() > 0) void'(drv_q[r].pop_front());
    end
    #1;
    for (int r = 0; r < NREQ; r++) begin
      if (drv_q[r].size() > 0) begin
        req_valid[r]         = 1'b1;
        req_is_unsigned[r]   = drv_q[r][0].uns;
        req_rm[2*r +: 2]     = drv_q[r][0].rm;
        req_i[32*r +: 32]    = drv_q[r][0].x;
      end else begin
        req_valid[r] = 1'b0;
      end
    end
  end

  // Compare process: expectations come from the model queue and round-robin pointer.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    bit head_vis, can_acc, found;
    int g, idx;
    acc_seen = req_valid & req_ready;
    pend_pop = 0;
    pend_acc = 0;
    if (rst) begin
      check("rst_req_ready",  32'(req_ready),  32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_idle",       32'(idle),       32'd1);
      check("rst_resp_f",     resp_f,          32'd0);
      check("rst_resp_id",    32'(resp_id),    32'd0);
    end else begin
      head_vis = (mq.size() > 0) && (mq[0].age >= 1);
      can_acc  = (mq.size() < 2) || resp_ready;
      found = 0;
      g = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found = 1;
          g = idx;
        end
      end
      exp_ready = '0;
      if (found && can_acc) exp_ready[g] = 1'b1;
      check("req_ready",  32'(req_ready),  32'(exp_ready));
      check("resp_valid", 32'(resp_valid), 32'(head_vis));
      check("idle",       32'(idle),       32'(mq.size() == 0));
      if (head_vis) begin
        check("resp_f",  resp_f,           mq[0].f);
        check("resp_id", 32'(resp_id),     32'(mq[0].id));
      end
      pend_pop = head_vis && resp_ready;
      if (found && can_acc) begin
        pend_acc = 1;
        pend_id  = g;
        pend_f   = model_cvt(req_is_unsigned[g], req_rm[2*g +: 2], req_i[32*g +: 32]);
      end
      for (int r = 0; r < NREQ; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          acc_cyc.push_back(cyc);
          acc_id.push_back(r);
        end
      end
      if (resp_valid && resp_ready) begin
        rsp_cyc.push_back(cyc);
        rsp_id.push_back(int'(resp_id));
        rsp_f.push_back(resp_f);
      end
    end
  end

  // Model state advance at the clock edge; entries become visible one edge after accept.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      m_ptr = 0;
    end else begin
      if (pend_pop) void'(mq.pop_front());
      foreach (mq[j]) mq[j].age++;
      if (pend_acc) begin
        mq.push_back('{pend_id, pend_f, 0});
        m_ptr = (pend_id + 1) % NREQ;
      end
    end
  end

  task automatic push(input int r, input bit uns, input bit [1:0] rm, input bit [31:0] x);
    op_t o;
    o.uns = uns;
    o.rm  = rm;
    o.x   = x;
    drv_q[r].push_back(o);
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    acc_id.delete();
    rsp_cyc.delete();
    rsp_id.delete();
    rsp_f.delete();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    @(negedge clk);
    while ((drv_q[0].size() + drv_q[1].size() + mq.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n >= 300), 32'd0);
  endtask

  bit [31:0] rt_x[10]   = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000001,
                            32'h80000001, 32'h01000001, 32'h01000003, 32'h80000000, 32'hFFFFFFFF};
  bit [1:0]  rt_rm[10]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
  bit        rt_uns[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  bit [31:0] rt_f[10]   = '{32'h4F000000, 32'h4EFFFFFF, 32'h4EFFFFFF, 32'h4F000000, 32'hCF000000,
                            32'hCEFFFFFF, 32'h4B800000, 32'h4B800002, 32'hCF000000, 32'h4F7FFFFF};
  bit [31:0] t2_f[3]    = '{32'hBF800000, 32'h4F800000, 32'h00000000};

  initial begin
    bit [31:0] held_f;
    req_valid       = '0;
    req_is_unsigned = '0;
    req_rm          = '0;
    req_i           = '0;
    resp_ready      = 1'b1;
    rst             = 1'b1;
    #1;
    check("init_resp_valid", 32'(resp_valid), 32'd0);
    check("init_idle",       32'(idle),       32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Single request on r0, latency and idle return.
    clear_logs();
    @(posedge clk); #2;
    push(0, 1'b0, 2'd0, 32'h00000001);
    wait_drain("t1");
    check("t1_nrsp", 32'(rsp_f.size()), 32'd1);
    if (rsp_f.size() > 0 && acc_cyc.size() > 0) begin
      check("t1_f",   rsp_f[0],                   32'h3F800000);
      check("t1_id",  32'(rsp_id[0]),             32'd0);
      check("t1_lat", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd2);
    end
    check("t1_idle", 32'(idle), 32'd1);

    // r1 signed/unsigned -1 and zero.
    clear_logs();
    @(posedge clk); #2;
    push(1, 1'b0, 2'd0, 32'hFFFFFFFF);
    push(1, 1'b1, 2'd0, 32'hFFFFFFFF);
    push(1, 1'b0, 2'd0, 32'h00000000);
    wait_drain("t2");
    check("t2_nrsp", 32'(rsp_f.size()), 32'd3);
    for (int k = 0; k < 3 && k < rsp_f.size(); k++) begin
      check("t2_f",  rsp_f[k],         t2_f[k]);
      check("t2_id", 32'(rsp_id[k]),   32'd1);
    end

    // Both requesters continuously valid: alternating grants, one response per cycle.
    clear_logs();
    @(posedge clk); #2;
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b0, 2'd0, 32'(1000 + k));
      push(1, 1'b0, 2'd0, 32'(-(2000 + k)));
    end
    wait_drain("t3");
    check("t3_nacc", 32'(acc_id.size()), 32'd8);
    check("t3_nrsp", 32'(rsp_id.size()), 32'd8);
    for (int k = 0; k < 8 && k < rsp_id.size() && k < acc_id.size(); k++) begin
      check("t3_grant", 32'(acc_id[k]), 32'(k % 2));
      check("t3_rspid", 32'(rsp_id[k]), 32'(k % 2));
      check("t3_rate",  32'(rsp_cyc[k] - rsp_cyc[0]), 32'(k));
    end

    // Rounding-mode and boundary vectors on r0.
    clear_logs();
    @(posedge clk); #2;
    for (int k = 0; k < 10; k++) push(0, rt_uns[k], rt_rm[k], rt_x[k]);
    wait_drain("t_rnd");
    check("rnd_nrsp", 32'(rsp_f.size()), 32'd10);
    for (int k = 0; k < 10 && k < rsp_f.size(); k++) check("rnd_f", rsp_f[k], rt_f[k]);

    // Backpressure: two accepts fill the pipe, then everything stalls.
    clear_logs();
    @(posedge clk); #2;
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b1, 2'd0, 32'(5 + k));
      push(1, 1'b0, 2'd3, 32'(-(77 + k)));
    end
    repeat (5) @(negedge clk);
    check("bp_nacc",  32'(acc_id.size()), 32'd2);
    check("bp_ready", 32'(req_ready),     32'd0);
    check("bp_valid", 32'(resp_valid),    32'd1);
    held_f = resp_f;
    @(negedge clk);
    check("bp_hold", resp_f, held_f);
    @(posedge clk); #2;
    resp_ready = 1'b1;
    wait_drain("t4");
    check("bp_nrsp", 32'(rsp_id.size()), 32'd8);
    for (int k = 0; k < 8 && k < rsp_id.size() && k < acc_id.size(); k++)
      check("bp_order", 32'(rsp_id[k]), 32'(acc_id[k]));

    // Asynchronous reset while S1 and S2 are both full.
    @(posedge clk); #2;
    resp_ready = 1'b0;
    push(0, 1'b0, 2'd0, 32'd11);
    push(0, 1'b0, 2'd0, 32'd12);
    repeat (4) @(negedge clk);
    check("mr_full", 32'(idle), 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mr_resp_valid", 32'(resp_valid), 32'd0);
    check("mr_idle",       32'(idle),       32'd1);
    check("mr_req_ready",  32'(req_ready),  32'd0);
    check("mr_resp_f",     resp_f,          32'd0);
    check("mr_resp_id",    32'(resp_id),    32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    resp_ready = 1'b1;
    clear_logs();
    push(0, 1'b0, 2'd0, 32'd21);
    push(1, 1'b0, 2'd0, 32'd22);
    wait_drain("t5");
    check("mr_nrsp", 32'(rsp_f.size()), 32'd2);
    if (acc_id.size() >= 2 && rsp_f.size() >= 2) begin
      check("mr_first_grant", 32'(acc_id[0]), 32'd0);
      check("mr_second_grant", 32'(acc_id[1]), 32'd1);
      check("mr_f0", rsp_f[0], 32'h41A80000);
      check("mr_f1", rsp_f[1], 32'h41B00000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
